dac_update_sched: RTL and testbench

- Owns the PLL enable sequencing and the 10-bit DAC update path in the mixed-signal user project.
- Brings the PLL up in a fixed order: charge pump first, then VCO, then a lock-wait.
- Once running, it shares the single DAC between two requesters (req0 = core output stream, req1 = host/LA override) with round-robin arbitration.
- DAC updates happen at a programmable rate; the last granted code is held between updates.

---
 rtl/dac_sched_pkg.sv | 17 +
 rtl/rr_arb2.sv | 21 ++
 rtl/dac_update_sched.sv | 136 +++++++++++++
 tb/tb_dac_update_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the PLL sequencer / DAC update scheduler.
package dac_sched_pkg;

  localparam int unsigned DW_DEF        = 10;
  localparam int unsigned DIVW_DEF      = 16;
  localparam int unsigned CP_SETTLE_DEF = 64;
  localparam int unsigned LOCK_WAIT_DEF = 1024;
  localparam logic [9:0]  MIDSCALE      = 10'h200;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_CP_ON  = 2'd1,
    ST_VCO_ON = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants only in a tick slot.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       tick,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On contention, the requester that was not granted last time wins.
  always_comb begin
    grant = 2'b00;
    if (tick) begin
      if (valid[0] && (!valid[1] || last_grant)) begin
        grant[0] = 1'b1;
      end else if (valid[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_update_sched.sv
// PLL enable sequencing plus rate-limited, round-robin shared DAC update path.
// Optional macro DAC_UNDERRUN_CNT_EN adds the underrun_cnt_o counter.
module dac_update_sched
  import dac_sched_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned DIVW      = DIVW_DEF,
  parameter int unsigned CP_SETTLE = CP_SETTLE_DEF,
  parameter int unsigned LOCK_WAIT = LOCK_WAIT_DEF
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            en_i,
  input  logic [DIVW-1:0] div_i,
  input  logic            req0_valid_i,
  input  logic [DW-1:0]   req0_data_i,
  output logic            req0_ready_o,
  input  logic            req1_valid_i,
  input  logic [DW-1:0]   req1_data_i,
  output logic            req1_ready_o,
  output logic            enb_cp_o,
  output logic            enb_vco_o,
  output logic            pll_ready_o,
  output logic [DW-1:0]   dac_d_o,
  output logic            tick_o
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [7:0]      underrun_cnt_o
`endif
);

  localparam int unsigned TMAX = (CP_SETTLE > LOCK_WAIT) ? CP_SETTLE : LOCK_WAIT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t          state, state_n;
  logic [TW-1:0]   timer;
  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] div_load;
  logic            tick;
  logic            last_grant;
  logic [1:0]      grant;

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_OFF;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!en_i) begin
      state_n = ST_OFF;
    end else begin
      case (state)
        ST_OFF:    state_n = ST_CP_ON;
        ST_CP_ON:  if (timer == TW'(CP_SETTLE - 1)) state_n = ST_VCO_ON;
        ST_VCO_ON: if (timer == TW'(LOCK_WAIT - 1)) state_n = ST_RUN;
        ST_RUN:    state_n = ST_RUN;
        default:   state_n = ST_OFF;
      endcase
    end
  end

  // Sequence timer restarts on every state change.
  always_ff @(posedge CLK) begin
    if (reset || (state_n != state)) begin
      timer <= '0;
    end else if ((state == ST_CP_ON) || (state == ST_VCO_ON)) begin
      timer <= timer + TW'(1);
    end
  end

  // PLL controls are registered from the next state so they change with it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      enb_cp_o    <= 1'b1;
      enb_vco_o   <= 1'b1;
      pll_ready_o <= 1'b0;
    end else begin
      enb_cp_o    <= (state_n == ST_OFF);
      enb_vco_o   <= (state_n == ST_OFF) || (state_n == ST_CP_ON);
      pll_ready_o <= (state_n == ST_RUN);
    end
  end

  assign div_load = (div_i == '0) ? '0 : (div_i - DIVW'(1));
  // Shutdown and reset suppress the slot so no handshake completes that cycle.
  assign tick     = (state == ST_RUN) && (div_cnt == '0) && en_i && !reset;
  assign tick_o   = tick;

  always_ff @(posedge CLK) begin
    if (reset || (state_n != ST_RUN)) begin
      div_cnt <= '0;
    end else if ((state != ST_RUN) || (div_cnt == '0)) begin
      div_cnt <= div_load;
    end else begin
      div_cnt <= div_cnt - DIVW'(1);
    end
  end

  rr_arb2 u_arb (
    .valid      ({req1_valid_i, req0_valid_i}),
    .tick       (tick),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_ff @(posedge CLK) begin
    if (reset) begin
      dac_d_o    <= DW'(MIDSCALE);
      last_grant <= 1'b1;
    end else if (!en_i) begin
      dac_d_o    <= DW'(MIDSCALE);
    end else if (grant[0]) begin
      dac_d_o    <= req0_data_i;
      last_grant <= 1'b0;
    end else if (grant[1]) begin
      dac_d_o    <= req1_data_i;
      last_grant <= 1'b1;
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  // Counts empty update slots while running; saturates.
  always_ff @(posedge CLK) begin
    if (reset || (state_n != ST_RUN)) begin
      underrun_cnt_o <= '0;
    end else if (tick && !req0_valid_i && !req1_valid_i && (underrun_cnt_o != 8'hFF)) begin
      underrun_cnt_o <= underrun_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_update_sched.sv
// Self-checking bench for dac_update_sched (CP_SETTLE=4, LOCK_WAIT=8).
module tb_dac_update_sched;

  localparam int unsigned DW   = 10;
  localparam int unsigned DIVW = 16;

  logic            CLK = 1'b0;
  logic            reset;
  logic            en_i;
  logic [DIVW-1:0] div_i;
  logic            req0_valid_i, req1_valid_i;
  logic [DW-1:0]   req0_data_i, req1_data_i;
  logic            req0_ready_o, req1_ready_o;
  logic            enb_cp_o, enb_vco_o, pll_ready_o, tick_o;
  logic [DW-1:0]   dac_d_o;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [7:0]      underrun_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          v0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic [DW-1:0] dac;
  } vec_t;
  vec_t vecs[10];

  dac_update_sched #(.CP_SETTLE(4), .LOCK_WAIT(8)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .en_i         (en_i),
    .div_i        (div_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .enb_cp_o     (enb_cp_o),
    .enb_vco_o    (enb_vco_o),
    .pll_ready_o  (pll_ready_o),
    .dac_d_o      (dac_d_o),
    .tick_o       (tick_o)
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Raises en_i and checks the enable ramp edge by edge; ends in the first RUN cycle.
  task automatic power_up();
    en_i = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      cyc();
      chk("pu_enb_cp", 32'(enb_cp_o), 32'(0));
      chk("pu_enb_vco", 32'(enb_vco_o), (n < 5) ? 32'(1) : 32'(0));
      chk("pu_pll_ready", 32'(pll_ready_o), (n >= 13) ? 32'(1) : 32'(0));
      if (n < 13) chk("pu_tick", 32'(tick_o), 32'(0));
    end
    chk("pu_dac", 32'(dac_d_o), 32'h200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] code;
    logic          exp_t;

    vecs[0] = '{1'b1, 10'h3FF, 1'b1, 10'h001, 1'b1, 1'b0, 10'h3FF};
    vecs[1] = '{1'b1, 10'h3FF, 1'b1, 10'h001, 1'b0, 1'b1, 10'h001};
    vecs[2] = '{1'b1, 10'h3FF, 1'b1, 10'h001, 1'b1, 1'b0, 10'h3FF};
    vecs[3] = '{1'b1, 10'h155, 1'b0, 10'h000, 1'b1, 1'b0, 10'h155};
    vecs[4] = '{1'b1, 10'h0AA, 1'b0, 10'h000, 1'b1, 1'b0, 10'h0AA};
    vecs[5] = '{1'b1, 10'h3FF, 1'b1, 10'h001, 1'b0, 1'b1, 10'h001};
    vecs[6] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h001};
    vecs[7] = '{1'b0, 10'h000, 1'b1, 10'h2A5, 1'b0, 1'b1, 10'h2A5};
    vecs[8] = '{1'b1, 10'h011, 1'b1, 10'h022, 1'b1, 1'b0, 10'h011};
    vecs[9] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h011};

    reset = 1'b1; en_i = 1'b0; div_i = 16'd1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_data_i = '0; req1_data_i = '0;
    cyc(); cyc();
    chk("rst_enb_cp", 32'(enb_cp_o), 32'(1));
    chk("rst_enb_vco", 32'(enb_vco_o), 32'(1));
    chk("rst_pll_ready", 32'(pll_ready_o), 32'(0));
    chk("rst_dac", 32'(dac_d_o), 32'h200);
    chk("rst_tick", 32'(tick_o), 32'(0));
    chk("rst_ready", 32'({req1_ready_o, req0_ready_o}), 32'(0));
    reset = 1'b0;

    // Arbitration table with a slot every cycle (div_i=1).
    power_up();
    for (int i = 0; i < 10; i++) begin
      req0_valid_i = vecs[i].v0; req0_data_i = vecs[i].d0;
      req1_valid_i = vecs[i].v1; req1_data_i = vecs[i].d1;
      #1;
      chk("tbl_tick", 32'(tick_o), 32'(1));
      chk("tbl_ready0", 32'(req0_ready_o), 32'(vecs[i].r0));
      chk("tbl_ready1", 32'(req1_ready_o), 32'(vecs[i].r1));
      exp_q.push_back(vecs[i].dac);
      cyc();
      chk("tbl_dac", 32'(dac_d_o), 32'(exp_q.pop_front()));
    end

    // Shutdown wins over a tick with req1 pending.
    req0_valid_i = 1'b0; req1_valid_i = 1'b1; req1_data_i = 10'h123; en_i = 1'b0;
    #1;
    chk("sd_ready1", 32'(req1_ready_o), 32'(0));
    chk("sd_tick", 32'(tick_o), 32'(0));
    cyc();
    chk("sd_enb_cp", 32'(enb_cp_o), 32'(1));
    chk("sd_enb_vco", 32'(enb_vco_o), 32'(1));
    chk("sd_pll_ready", 32'(pll_ready_o), 32'(0));
    chk("sd_dac", 32'(dac_d_o), 32'h200);
    req1_valid_i = 1'b0;

    // Rate: div_i=5, then div_i=0 picked up at the next reload.
    div_i = 16'd5; code = 10'h040;
    req0_valid_i = 1'b1; req0_data_i = code;
    power_up();
    for (int k = 0; k < 26; k++) begin
      if (k == 15) div_i = 16'd0;
      #1;
      exp_t = (k < 20) ? ((k % 5) == 4) : 1'b1;
      chk("rate_tick", 32'(tick_o), 32'(exp_t));
      chk("rate_ready0", 32'(req0_ready_o), 32'(exp_t));
      if (exp_t) exp_q.push_back(code);
      cyc();
      if (exp_t) begin
        chk("rate_dac", 32'(dac_d_o), 32'(exp_q.pop_front()));
        code = code + 10'd1;
        req0_data_i = code;
      end
    end
    req0_valid_i = 1'b0;

    // Reset during VCO_ON, then the same ramp again.
    en_i = 1'b0; div_i = 16'd1;
    cyc();
    en_i = 1'b1;
    for (int n = 0; n < 7; n++) cyc();
    chk("mr_in_vco", 32'({enb_cp_o, enb_vco_o}), 32'(0));
    reset = 1'b1;
    cyc();
    chk("mr_enb_cp", 32'(enb_cp_o), 32'(1));
    chk("mr_enb_vco", 32'(enb_vco_o), 32'(1));
    chk("mr_pll_ready", 32'(pll_ready_o), 32'(0));
    chk("mr_dac", 32'(dac_d_o), 32'h200);
    chk("mr_tick", 32'(tick_o), 32'(0));
    reset = 1'b0;
    power_up();

    // Empty slots: no ready, DAC holds.
    for (int n = 0; n < 300; n++) begin
      if (n == 3) begin
        chk("ur_ready", 32'({req1_ready_o, req0_ready_o}), 32'(0));
`ifdef DAC_UNDERRUN_CNT_EN
        chk("ur_cnt3", 32'(underrun_cnt_o), 32'(3));
`endif
      end
      cyc();
    end
    chk("ur_dac_hold", 32'(dac_d_o), 32'h200);
`ifdef DAC_UNDERRUN_CNT_EN
    chk("ur_cnt_sat", 32'(underrun_cnt_o), 32'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
